// File: rtl/pattern_pkg.sv
// rtl/pattern_pkg.sv - shared encodings and defaults for the pattern link
package pattern_pkg;

    localparam int DEF_PAT_W = 3;
    localparam logic [DEF_PAT_W-1:0] CANON_PAT = 3'b010;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Receiver-side (010 detector) state encodings, kept here so both ends agree
    localparam logic [1:0] DET_S0 = 2'd0;
    localparam logic [1:0] DET_S1 = 2'd1;
    localparam logic [1:0] DET_S2 = 2'd2;

    typedef enum logic [1:0] {
        TX_IDLE  = ST_IDLE,
        TX_SHIFT = ST_SHIFT,
        TX_GAP   = ST_GAP,
        TX_DONE  = ST_DONE
    } tx_state_t;

endpackage

// File: rtl/pattern_shreg.sv
// rtl/pattern_shreg.sv - loadable MSB-first shift register
module pattern_shreg #(
    parameter int PAT_W = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic             shift,
    input  logic [PAT_W-1:0] din,
    output logic             msb
);

    logic [PAT_W-1:0] q;

    // load takes priority so a back-to-back reload replaces the final shift
    always_ff @(posedge clk) begin
        if (!rstn) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {q[PAT_W-2:0], 1'b0};
        end
    end

    assign msb = q[PAT_W-1];

endmodule

// File: rtl/pattern_tx.sv
// rtl/pattern_tx.sv - serial pattern transmitter with repeat count and idle gaps
module pattern_tx
    import pattern_pkg::*;
#(
    parameter int PAT_W    = DEF_PAT_W,
    parameter int CNT_W    = 4,
    parameter int GAP      = 1,
    parameter bit IDLE_BIT = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic             abort,
    output logic             data_out,
    output logic             data_valid,
    output logic             busy,
    output logic             done
);

    localparam int BW       = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam int GW       = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

    tx_state_t        state;
    logic [PAT_W-1:0] pat_q;
    logic [CNT_W-1:0] copy_cnt;
    logic [BW-1:0]    bit_cnt;
    logic [GW-1:0]    gap_cnt;

    logic             last_bit;
    logic             gap_last;
    logic             sh_load;
    logic             sh_shift;
    logic             sh_msb;
    logic [PAT_W-1:0] sh_din;

    assign last_bit = (bit_cnt == BW'(PAT_W - 1));
    assign gap_last = (gap_cnt == GW'(GAP_LAST));

    always_comb begin
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        sh_din   = (state == TX_IDLE) ? pattern : pat_q;
        case (state)
            TX_IDLE: begin
                sh_load = start && !abort;
            end
            TX_SHIFT: begin
                sh_shift = !abort;
                sh_load  = !abort && last_bit && (copy_cnt != '0) && (GAP == 0);
            end
            TX_GAP: begin
                sh_load = !abort && gap_last;
            end
            default: begin
                sh_load = 1'b0;
            end
        endcase
    end

    pattern_shreg #(
        .PAT_W (PAT_W)
    ) u_shreg (
        .clk   (clk),
        .rstn  (rstn),
        .load  (sh_load),
        .shift (sh_shift),
        .din   (sh_din),
        .msb   (sh_msb)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= TX_IDLE;
            pat_q      <= '0;
            copy_cnt   <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            data_out   <= IDLE_BIT;
            data_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                TX_IDLE: begin
                    data_out   <= IDLE_BIT;
                    data_valid <= 1'b0;
                    busy       <= 1'b0;
                    if (start && !abort) begin
                        pat_q    <= pattern;
                        copy_cnt <= repeat_cnt;
                        bit_cnt  <= '0;
                        gap_cnt  <= '0;
                        state    <= TX_SHIFT;
                    end
                end
                TX_SHIFT: begin
                    if (abort) begin
                        data_out   <= IDLE_BIT;
                        data_valid <= 1'b0;
                        busy       <= 1'b0;
                        bit_cnt    <= '0;
                        state      <= TX_IDLE;
                    end else begin
                        data_out   <= sh_msb;
                        data_valid <= 1'b1;
                        busy       <= 1'b1;
                        if (last_bit) begin
                            bit_cnt <= '0;
                            if (copy_cnt == '0) begin
                                state <= TX_DONE;
                            end else begin
                                copy_cnt <= copy_cnt - 1'b1;
                                if (GAP > 0) begin
                                    gap_cnt <= '0;
                                    state   <= TX_GAP;
                                end
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                TX_GAP: begin
                    data_out   <= IDLE_BIT;
                    data_valid <= 1'b0;
                    if (abort) begin
                        busy    <= 1'b0;
                        gap_cnt <= '0;
                        state   <= TX_IDLE;
                    end else begin
                        busy <= 1'b1;
                        if (gap_last) begin
                            gap_cnt <= '0;
                            state   <= TX_SHIFT;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                end
                TX_DONE: begin
                    data_out   <= IDLE_BIT;
                    data_valid <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    state      <= TX_IDLE;
                end
                default: begin
                    state <= TX_IDLE;
                end
            endcase
        end
    end

endmodule
